fft_bfly_sequencer: RTL and testbench
=====================================

Name: fft_bfly_sequencer

Overview:
- Sequencer for an in-place radix-2 DIT FFT built around one shared, pipelined butterfly unit and a dual-port sample RAM.
- On each start it walks all LOG2_N stages and issues one butterfly per cycle.
- Per butterfly it drives the two RAM read addresses, the twiddle ROM index, and the matching delayed write-back addresses.
- It inserts a stage barrier so reads of stage s+1 never overtake writes of stage s.

Parameters:
- LOG2_N, 4, log2 of FFT size; N = 2**LOG2_N; legal range 2..12.
- BFLY_LATENCY, 2, cycles from butterfly operand read (rd_en) to result write (wr_en); legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a transform; sampled only in IDLE.
- busy  out  1  high from the first issue cycle through the final write cycle.
- done  out  1  one-cycle pulse the cycle after the final wr_en.
- stage  out  LOG2_N  current issue stage index; 0 when idle.
- rd_en  out  1  butterfly operand read/issue strobe.
- rd_addr0  out  LOG2_N  upper-leg (x0) read address.
- rd_addr1  out  LOG2_N  lower-leg (x1) read address.
- tw_idx  out  LOG2_N-1  twiddle ROM index, valid with rd_en.
- wr_en  out  1  write-back strobe; rd_en delayed BFLY_LATENCY cycles.
- wr_addr0  out  LOG2_N  write address for butterfly out0.
- wr_addr1  out  LOG2_N  write address for butterfly out1.

Behaviour:
- All outputs are registered.
- Reset (rst_n low, asynchronous): state=IDLE, all outputs 0, write pipeline valid bits cleared. Reset mid-transform aborts immediately: no further wr_en and no done pulse.
- States: IDLE, ISSUE, GAP, FLUSH.
- IDLE:
  - busy=0.
  - start=1 at edge T moves to ISSUE with stage=0, b=0.
  - The first rd_en is high in cycle T+1.
- ISSUE:
  - rd_en=1 each cycle.
  - Butterfly counter b runs 0..N/2-1. For stage s: half=1<<s, grp=b>>s, pos=b&(half-1).
  - rd_addr0 = (grp<<(s+1)) | pos; rd_addr1 = rd_addr0 + half.
  - tw_idx = pos << (LOG2_N-1-s), truncated to LOG2_N-1 bits.
  - After b=N/2-1: go to GAP if s<LOG2_N-1, else FLUSH.
- GAP:
  - rd_en=0 for exactly BFLY_LATENCY cycles.
  - Then s increments, b=0, and the state returns to ISSUE.
  - Guarantees the last write of stage s lands in the cycle before the first read of stage s+1.
- FLUSH: wait until the write pipeline is empty (BFLY_LATENCY cycles), then pulse done for one cycle and return to IDLE.
- Write pipeline:
  - Shift register of depth BFLY_LATENCY carrying {valid, addr0, addr1}.
  - wr_en/wr_addr* equal rd_en/rd_addr* from BFLY_LATENCY cycles earlier.
  - The pipeline never stalls, because the butterfly datapath has no enable.
- busy: high in every cycle where state≠IDLE or a pipeline valid bit is set; low in the done cycle.
- Timing: total cycles from the first rd_en to the last wr_en inclusive = LOG2_N*(N/2+BFLY_LATENCY). For the defaults that is 40 cycles: rd_en in cycles 1..38 (with gaps), last wr_en in cycle 40, done in cycle 41.
- start while busy or in the done cycle is ignored; it is not queued.
- stage holds its value through GAP, returns to 0 in IDLE.

Optional Feature:
- Macro: FFT_BFLY_SEQ_STALL_EN.
- Defined:
  - Adds input port `stall` (1 bit).
  - While stall=1 in ISSUE, no issue occurs: rd_en=0 and b/s hold. Issue resumes with the same b when stall drops.
  - The write pipeline keeps draining during stall.
  - The GAP counter only starts after the last issue of a stage, so stall before that point does not shorten the barrier. stall in GAP/FLUSH/IDLE has no effect.
- Undefined: no stall port; issue is never interrupted.

Test Plan:
- Reset then start pulse at T (defaults) -> cycle T+1: rd_en=1, rd_addr0=0, rd_addr1=1, tw_idx=0; cycle T+2: addr 2/3, tw 0; wr_en first high at T+3 with wr_addr0=0, wr_addr1=1.
- Stage 1 check -> second issue of stage 1 (b=1): rd_addr0=1, rd_addr1=3, tw_idx=4; stage 3 b=7: rd_addr0=7, rd_addr1=15, tw_idx=7.
- Barrier/timing -> rd_en low exactly 2 cycles between stages; 32 total rd_en pulses and 32 wr_en pulses; done pulses once at T+41; busy high T+1..T+40.
- start held high throughout the transform -> exactly one transform runs; a new transform starts only if start is still high in IDLE after done.
- rst_n low at T+20 -> all outputs 0 asynchronously; no wr_en and no done afterwards; a fresh start runs a full 40-cycle transform.
- FFT_BFLY_SEQ_STALL_EN defined, stall high 3 cycles at T+5 -> rd_en low those 3 cycles, addresses resume at b=4 (rd_addr0=8, rd_addr1=9); done delayed to T+44; wr_en stream is not interrupted by the stall.

Source files
------------

// File: rtl/fft_bfly_sequencer.sv
// fft_bfly_sequencer: in-place radix-2 DIT FFT butterfly issue sequencer with stage barrier
// Optional FFT_BFLY_SEQ_STALL_EN adds a stall input that pauses issue within a stage.
module fft_bfly_sequencer #(
  parameter int LOG2_N       = 4,
  parameter int BFLY_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef FFT_BFLY_SEQ_STALL_EN
  input  logic              stall,
`endif
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [LOG2_N-1:0] stage,
  output logic              rd_en,
  output logic [LOG2_N-1:0] rd_addr0,
  output logic [LOG2_N-1:0] rd_addr1,
  output logic [LOG2_N-2:0] tw_idx,
  output logic              wr_en,
  output logic [LOG2_N-1:0] wr_addr0,
  output logic [LOG2_N-1:0] wr_addr1
);
  localparam int CW = $clog2(BFLY_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, FLUSH} state_t;
  state_t state_q, state_d;
  logic [LOG2_N-2:0] b_q, b_d, ib;
  logic [LOG2_N-1:0] s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic issue, busy_d, done_d, stall_w;
  logic [LOG2_N-1:0] half, pos, a0, twf;
  logic busy_q, done_q, rd_en_q;
  logic [LOG2_N-1:0] rd_addr0_q, rd_addr1_q;
  logic [LOG2_N-2:0] tw_idx_q;
  logic [BFLY_LATENCY-1:0] pv_q;
  logic [BFLY_LATENCY-1:0][LOG2_N-1:0] pa0_q, pa1_q;
`ifdef FFT_BFLY_SEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q + 1'b1;
    done_d  = 1'b0;
    issue   = 1'b0;
    ib      = b_q;
    case (state_q)
      IDLE: if (start && !done_q) begin
        issue = 1'b1;
        ib    = '0;
        s_d   = '0;
      end
      ISSUE: issue = !stall_w;
      GAP: if (cnt_q == CW'(BFLY_LATENCY)) begin
        issue = 1'b1;
        ib    = '0;
        s_d   = s_q + 1'b1;
      end
      default: if (cnt_q == CW'(BFLY_LATENCY)) begin
        done_d  = 1'b1;
        state_d = IDLE;
        s_d     = '0;
      end
    endcase
    if (issue) begin
      b_d     = ib + 1'b1;
      cnt_d   = '0;
      state_d = (ib != '1) ? ISSUE : (s_d == LOG2_N'(LOG2_N - 1)) ? FLUSH : GAP;
    end
    // grp<<(s+1) | pos splits b around bit s to form the upper-leg address
    half = LOG2_N'(1) << s_d;
    pos  = {1'b0, ib} & (half - 1'b1);
    a0   = (({1'b0, ib} >> s_d) << (s_d + 1'b1)) | pos;
    twf  = pos << (LOG2_N'(LOG2_N - 1) - s_d);
    busy_d = (state_d != IDLE) | rd_en_q;
    for (int i = 0; i < BFLY_LATENCY - 1; i++) busy_d = busy_d | pv_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      b_q        <= '0;
      s_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr0_q <= '0;
      rd_addr1_q <= '0;
      tw_idx_q   <= '0;
      pv_q       <= '0;
      pa0_q      <= '0;
      pa1_q      <= '0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= issue;
      if (issue) begin
        rd_addr0_q <= a0;
        rd_addr1_q <= a0 + half;
        tw_idx_q   <= twf[LOG2_N-2:0];
      end
      pv_q[0]  <= rd_en_q;
      pa0_q[0] <= rd_addr0_q;
      pa1_q[0] <= rd_addr1_q;
      for (int i = 1; i < BFLY_LATENCY; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pa0_q[i] <= pa0_q[i-1];
        pa1_q[i] <= pa1_q[i-1];
      end
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign stage    = s_q;
  assign rd_en    = rd_en_q;
  assign rd_addr0 = rd_addr0_q;
  assign rd_addr1 = rd_addr1_q;
  assign tw_idx   = tw_idx_q;
  assign wr_en    = pv_q[BFLY_LATENCY-1];
  assign wr_addr0 = pa0_q[BFLY_LATENCY-1];
  assign wr_addr1 = pa1_q[BFLY_LATENCY-1];
endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// tb_fft_bfly_sequencer: scoreboard bench for fft_bfly_sequencer (default parameters)
// Exercises the stall path too when FFT_BFLY_SEQ_STALL_EN is defined.
module tb_fft_bfly_sequencer;
  localparam int LOG2_N = 4, L = 2, N = 1 << LOG2_N, H = N / 2, TOT = LOG2_N * (H + L);
  logic clk = 0, rst_n = 1, start = 0, stall = 0;
  logic busy, done, rd_en, wr_en;
  logic [LOG2_N-1:0] stage, rd_addr0, rd_addr1, wr_addr0, wr_addr1;
  logic [LOG2_N-2:0] tw_idx;
  typedef struct {int cyc; int a0; int a1; int tw; int st;} exp_t;
  exp_t rd_q[$], wr_q[$], me;
  int done_q[$], blo[$], bhi[$];
  int cyc = 0, checks = 0, errors = 0, n_rd = 0, n_wr = 0, ts = 0;

  fft_bfly_sequencer #(.LOG2_N(LOG2_N), .BFLY_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef FFT_BFLY_SEQ_STALL_EN
    .stall(stall),
`endif
    .start(start), .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .tw_idx(tw_idx),
    .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected schedule for one transform whose first issue is seen at cycle t0;
  // issues from stage-0 butterfly sb onward slip by sl stall cycles.
  task automatic push_transform(input int t0, input int sb, input int sl);
    for (int s = 0; s < LOG2_N; s++)
      for (int b = 0; b < H; b++) begin
        int half, pos, a, off;
        half = 1 << s;
        pos  = b % half;
        a    = 2 * b - pos;
        off  = s * (H + L) + b + ((s > 0 || b >= sb) ? sl : 0);
        rd_q.push_back('{t0 + off, a, a + half, pos * (H / half), s});
        wr_q.push_back('{t0 + off + L, a, a + half, 0, 0});
      end
    done_q.push_back(t0 + TOT + sl);
    blo.push_back(t0);
    bhi.push_back(t0 + TOT + sl - 1);
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 2000 && cyc != c; i++) @(negedge clk);
    chk("wait_cycle", cyc, c);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done_q.size() != 0; i++) @(negedge clk);
    chk("done_timeout", done_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("wr_queue_drained", wr_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr0"}, rd_addr0, 0);
    chk({tag, "_rd_addr1"}, rd_addr1, 0);
    chk({tag, "_tw_idx"}, tw_idx, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr0"}, wr_addr0, 0);
    chk({tag, "_wr_addr1"}, wr_addr1, 0);
  endtask

  task automatic pulse_start(input int sb, input int sl);
    @(negedge clk);
    start = 1;
    ts = cyc + 1;
    push_transform(ts, sb, sl);
    @(negedge clk);
    start = 0;
  endtask

  always @(negedge clk) if (rst_n) begin
    int bexp;
    bexp = 0;
    for (int i = 0; i < blo.size(); i++) if (cyc >= blo[i] && cyc <= bhi[i]) bexp = 1;
    chk("busy", busy, bexp);
    if (rd_en) n_rd++;
    if (wr_en) n_wr++;
    if (rd_q.size() != 0 && rd_q[0].cyc == cyc) begin
      me = rd_q.pop_front();
      chk("rd_en", rd_en, 1);
      chk("rd_addr0", rd_addr0, me.a0);
      chk("rd_addr1", rd_addr1, me.a1);
      chk("tw_idx", tw_idx, me.tw);
      chk("stage", stage, me.st);
    end else chk("rd_en_quiet", rd_en, 0);
    if (wr_q.size() != 0 && wr_q[0].cyc == cyc) begin
      me = wr_q.pop_front();
      chk("wr_en", wr_en, 1);
      chk("wr_addr0", wr_addr0, me.a0);
      chk("wr_addr1", wr_addr1, me.a1);
    end else chk("wr_en_quiet", wr_en, 0);
    if (done_q.size() != 0 && done_q[0] == cyc) begin
      chk("done", done, 1);
      void'(done_q.pop_front());
    end else chk("done_quiet", done, 0);
  end

  initial begin
    #1 rst_n = 0;
    #12 chk_zero("reset");
    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk);
    // single transform: addresses, barrier gaps, counts, done/busy timing
    n_rd = 0; n_wr = 0;
    pulse_start(H, 0);
    wait_done();
    chk("rd_count", n_rd, H * LOG2_N);
    chk("wr_count", n_wr, H * LOG2_N);
    // start held high: ignored while busy and in the done cycle
    @(negedge clk);
    start = 1;
    ts = cyc + 1;
    push_transform(ts, H, 0);
    push_transform(ts + TOT + 2, H, 0);
    wait_cyc(ts + TOT + 2);
    start = 0;
    wait_done();
    // asynchronous reset mid-transform aborts everything
    pulse_start(H, 0);
    wait_cyc(ts + 19);
    #2 rst_n = 0;
    #1 chk_zero("abort");
    rd_q.delete(); wr_q.delete(); done_q.delete(); blo.delete(); bhi.delete();
    @(negedge clk) rst_n = 1;
    repeat (10) @(negedge clk);
    n_rd = 0; n_wr = 0;
    pulse_start(H, 0);
    wait_done();
    chk("rd_count_after_abort", n_rd, H * LOG2_N);
    chk("wr_count_after_abort", n_wr, H * LOG2_N);
`ifdef FFT_BFLY_SEQ_STALL_EN
    // three stall cycles after the fourth stage-0 issue
    pulse_start(4, 3);
    wait_cyc(ts + 3);
    stall = 1;
    wait_cyc(ts + 6);
    stall = 0;
    wait_done();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
